// File: rtl/ct_lsu_store_merge_buffer.sv
// ---------------------------------------------------------------------------
// ct_lsu_store_merge_buffer
//
// Single-entry, 16-byte store merge buffer between store commit and the
// dcache write port. Committed stores that fall in the same 16B-aligned
// segment are merged byte-by-byte into one entry. The entry is drained to
// the dcache with one req/grant write. Buffered bytes are forwarded to the
// load DC stage.
//
// Ports:
//   forever_cpuclk, cpurst         clock, synchronous active-high reset
//   cp0_lsu_smb_dis                disable: no allocation, live entry drains
//   icc_idle                       0 = cache maintenance busy: drain, no alloc
//   st_smb_*                       committed store (valid/addr/data/byte en)
//   smb_st_ready                   store accepted when st_smb_vld && ready
//   lsu_smb_flush_req              fence/sync request to empty the buffer
//   smb_empty                      buffer holds no entry
//   smb_dcache_wr_*                dcache write request / payload
//   dcache_smb_wr_grant            dcache accepted the write this cycle
//   ld_dc_addr1                    load DC-stage address
//   smb_ld_dc_*                    forwarding hit, entry data, valid bytes
// ---------------------------------------------------------------------------
module ct_lsu_store_merge_buffer #(
  parameter int PA_WIDTH = 40,
  parameter int TIMEOUT  = 8
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  cp0_lsu_smb_dis,
  input  logic                  icc_idle,
  input  logic                  st_smb_vld,
  input  logic [PA_WIDTH-5:0]   st_smb_addr_tto4,
  input  logic [127:0]          st_smb_data,
  input  logic [15:0]           st_smb_bytes_vld,
  output logic                  smb_st_ready,
  input  logic                  lsu_smb_flush_req,
  output logic                  smb_empty,
  output logic                  smb_dcache_wr_req,
  output logic [PA_WIDTH-5:0]   smb_dcache_wr_addr_tto4,
  output logic [127:0]          smb_dcache_wr_data,
  output logic [15:0]           smb_dcache_wr_be,
  input  logic                  dcache_smb_wr_grant,
  input  logic [PA_WIDTH-1:0]   ld_dc_addr1,
  output logic                  smb_ld_dc_addr_hit,
  output logic [127:0]          smb_ld_dc_data,
  output logic [15:0]           smb_ld_dc_bytes_vld
);

  localparam int TW = PA_WIDTH - 4;
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MERGE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] tag;
  logic [127:0]  data;
  logic [15:0]   mask;
  logic [3:0]    idle_cnt;

  logic          tag_hit;
  logic          cnt_max;
  logic          alloc_ok;
  logic          ready;
  logic          accept;
  logic [127:0]  merged_data;
  logic [15:0]   merged_mask;
  logic          drain_now;

  // The low four load-address bits select a byte inside the segment and
  // play no part in the segment match.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_dc_addr1[3:0];

  assign tag_hit  = (tag == st_smb_addr_tto4);
  assign cnt_max  = (idle_cnt == TIMEOUT_CNT);
  assign alloc_ok = !cp0_lsu_smb_dis && icc_idle && !lsu_smb_flush_req;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      EMPTY:   ready = alloc_ok;
      MERGE:   ready = tag_hit && alloc_ok && !cnt_max;
      default: ready = 1'b0;
    endcase
    if (cpurst) ready = 1'b0;
  end

  assign accept = st_smb_vld && ready;

  // Younger store bytes replace older ones lane by lane.
  always_comb begin
    merged_data = data;
    for (int i = 0; i < 16; i++) begin
      if (accept && st_smb_bytes_vld[i]) merged_data[i*8 +: 8] = st_smb_data[i*8 +: 8];
    end
  end

  assign merged_mask = accept ? (mask | st_smb_bytes_vld) : mask;

  // A store to another segment cannot merge, so the entry must leave to let
  // it allocate; the store itself waits at the source.
  assign drain_now = (merged_mask == 16'hFFFF) || cnt_max || lsu_smb_flush_req ||
                     cp0_lsu_smb_dis || !icc_idle || (st_smb_vld && !tag_hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= EMPTY;
      tag      <= '0;
      data     <= '0;
      mask     <= '0;
      idle_cnt <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            tag      <= st_smb_addr_tto4;
            data     <= st_smb_data;
            mask     <= st_smb_bytes_vld;
            idle_cnt <= '0;
            state    <= MERGE;
          end
        end
        MERGE: begin
          data <= merged_data;
          mask <= merged_mask;
          if (accept)        idle_cnt <= '0;
          else if (!cnt_max) idle_cnt <= idle_cnt + 4'd1;
          if (drain_now) state <= DRAIN;
        end
        DRAIN: begin
          // Payload is held until the grant edge, then the entry is cleared
          // so an empty buffer presents all-zero outputs.
          if (dcache_smb_wr_grant) begin
            state    <= EMPTY;
            tag      <= '0;
            data     <= '0;
            mask     <= '0;
            idle_cnt <= '0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign smb_st_ready            = ready;
  assign smb_empty               = (state == EMPTY);
  assign smb_dcache_wr_req       = (state == DRAIN);
  assign smb_dcache_wr_addr_tto4 = tag;
  assign smb_dcache_wr_data      = data;
  assign smb_dcache_wr_be        = mask;

  // Forwarding uses registered contents, so a same-cycle store is not seen.
  assign smb_ld_dc_addr_hit  = (state != EMPTY) && (tag == ld_dc_addr1[PA_WIDTH-1:4]);
  assign smb_ld_dc_data      = data;
  assign smb_ld_dc_bytes_vld = mask;

endmodule

// File: tb/tb_ct_lsu_store_merge_buffer.sv
// ---------------------------------------------------------------------------
// tb_ct_lsu_store_merge_buffer
//
// Directed scenarios followed by randomized traffic, all checked each cycle
// against a byte-array model of the merge buffer.
// ---------------------------------------------------------------------------
module tb_ct_lsu_store_merge_buffer;

  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dis;
  logic          icc;
  logic          st_vld;
  logic [35:0]   st_addr;
  logic [127:0]  st_data;
  logic [15:0]   st_be;
  logic          rdy;
  logic          flush;
  logic          empty;
  logic          wr_req;
  logic [35:0]   wr_addr;
  logic [127:0]  wr_data;
  logic [15:0]   wr_be;
  logic          grant;
  logic [39:0]   ld_addr;
  logic          hit;
  logic [127:0]  ld_data;
  logic [15:0]   ld_bv;

  ct_lsu_store_merge_buffer #(.PA_WIDTH(40), .TIMEOUT(TIMEOUT)) dut (
    .forever_cpuclk          (clk),
    .cpurst                  (rst),
    .cp0_lsu_smb_dis         (dis),
    .icc_idle                (icc),
    .st_smb_vld              (st_vld),
    .st_smb_addr_tto4        (st_addr),
    .st_smb_data             (st_data),
    .st_smb_bytes_vld        (st_be),
    .smb_st_ready            (rdy),
    .lsu_smb_flush_req       (flush),
    .smb_empty               (empty),
    .smb_dcache_wr_req       (wr_req),
    .smb_dcache_wr_addr_tto4 (wr_addr),
    .smb_dcache_wr_data      (wr_data),
    .smb_dcache_wr_be        (wr_be),
    .dcache_smb_wr_grant     (grant),
    .ld_dc_addr1             (ld_addr),
    .smb_ld_dc_addr_hit      (hit),
    .smb_ld_dc_data          (ld_data),
    .smb_ld_dc_bytes_vld     (ld_bv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an entry is a set of byte slots, each with a value and
  // a valid flag, plus a count of consecutive cycles without a merge.
  bit          m_live;
  bit          m_drain;
  logic [35:0] m_tag;
  logic [7:0]  m_byte [16];
  bit          m_bv   [16];
  int          m_idle;

  task automatic model_clear();
    m_live  = 0;
    m_drain = 0;
    m_tag   = '0;
    m_idle  = 0;
    for (int i = 0; i < 16; i++) begin
      m_byte[i] = 8'h00;
      m_bv[i]   = 0;
    end
  endtask

  function automatic logic [127:0] model_data();
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = m_byte[i];
    return d;
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = m_bv[i];
    return m;
  endfunction

  function automatic bit model_ready();
    if (rst)     return 0;
    if (!m_live) return !dis && icc && !flush;
    if (m_drain) return 0;
    return (st_addr == m_tag) && !dis && icc && !flush && (m_idle < TIMEOUT);
  endfunction

  // Called with inputs already applied after a falling edge: compares all
  // outputs, advances the model across the next rising edge, and returns at
  // the following falling edge.
  task automatic step();
    bit exp_rdy, acc, timed_out, full;
    #1;
    exp_rdy = model_ready();
    check("ready",    128'(rdy),     128'(exp_rdy));
    check("empty",    128'(empty),   128'(!m_live));
    check("wr_req",   128'(wr_req),  128'(m_drain));
    check("wr_addr",  128'(wr_addr), 128'(m_tag));
    check("wr_data",  wr_data,       model_data());
    check("wr_be",    128'(wr_be),   128'(model_mask()));
    check("ld_hit",   128'(hit),     128'(m_live && (m_tag == ld_addr[39:4])));
    check("ld_data",  ld_data,       model_data());
    check("ld_bv",    128'(ld_bv),   128'(model_mask()));

    if (rst) begin
      model_clear();
    end else if (!m_live) begin
      if (st_vld && exp_rdy) begin
        m_live = 1;
        m_tag  = st_addr;
        m_idle = 0;
        for (int i = 0; i < 16; i++) begin
          m_byte[i] = st_data[i*8 +: 8];
          m_bv[i]   = st_be[i];
        end
      end
    end else if (m_drain) begin
      if (grant) model_clear();
    end else begin
      acc       = st_vld && exp_rdy;
      timed_out = (m_idle >= TIMEOUT);
      if (acc) begin
        for (int i = 0; i < 16; i++) begin
          if (st_be[i]) begin
            m_byte[i] = st_data[i*8 +: 8];
            m_bv[i]   = 1;
          end
        end
        m_idle = 0;
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
      end
      full = (model_mask() == 16'hFFFF);
      if (full || timed_out || flush || dis || !icc || (st_vld && (st_addr != m_tag)))
        m_drain = 1;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; dis = 0; icc = 1; flush = 0; grant = 0;
    st_vld = 0; st_addr = '0; st_data = '0; st_be = '0;
  endtask

  task automatic store(input logic [35:0] a, input logic [15:0] be, input logic [127:0] d);
    st_vld  = 1;
    st_addr = a;
    st_be   = be;
    st_data = d;
  endtask

  int waited;

  initial begin
    quiet();
    rst     = 1;
    ld_addr = 40'h10;
    repeat (2) @(negedge clk);
    model_clear();
    step();                                  // reset state checked by model
    rst = 0;

    // Allocation from EMPTY and forwarding of the new entry.
    store(36'h1, 16'h000F, {16{8'hAA}});
    #1 check("alloc_ready", 128'(rdy), 128'(1));
    step();
    st_vld = 0;
    #1;
    check("alloc_empty", 128'(empty), 128'(0));
    check("alloc_hit",   128'(hit),   128'(1));
    check("alloc_bv",    128'(ld_bv), 128'(16'h000F));
    step();

    // Merge to a full mask, then drain.
    store(36'h1, 16'h00F0, {16{8'hBB}});
    step();
    store(36'h1, 16'hFF00, {16{8'hCC}});
    step();
    st_vld = 0;
    #1;
    check("full_wr_req", 128'(wr_req), 128'(1));
    check("full_wr_be",  128'(wr_be),  128'(16'hFFFF));
    grant = 1;
    step();
    grant = 0;
    #1 check("full_empty", 128'(empty), 128'(1));
    step();

    // Overlap: younger store wins byte 0, then idle timeout.
    store(36'h1, 16'h0001, {16{8'h11}});
    step();
    store(36'h1, 16'h0001, {16{8'h22}});
    step();
    st_vld = 0;
    #1 check("overlap_byte0", 128'(ld_data[7:0]), 128'(8'h22));
    waited = 0;
    while (!wr_req && waited < 3 * TIMEOUT) begin
      step();
      waited++;
    end
    check("timeout_wait", 128'(waited), 128'(TIMEOUT + 1));
    grant = 1;
    step();
    grant = 0;

    // Address conflict: drain tag 1 with a held store to tag 2.
    store(36'h1, 16'h0003, {16{8'h33}});
    step();
    store(36'h2, 16'h0300, {16{8'h44}});
    #1 check("conflict_ready", 128'(rdy), 128'(0));
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("conflict_wr_req",  128'(wr_req),  128'(1));
      check("conflict_wr_addr", 128'(wr_addr), 128'(36'h1));
      check("conflict_wr_be",   128'(wr_be),   128'(16'h0003));
      step();
    end
    grant = 1;
    step();
    grant = 0;
    #1 check("held_store_ready", 128'(rdy), 128'(1));
    step();
    st_vld  = 0;
    ld_addr = 40'h20;
    #1 check("held_store_hit", 128'(hit), 128'(1));
    step();

    // Flush request drains and blocks allocation.
    flush = 1;
    #1 check("flush_ready", 128'(rdy), 128'(0));
    step();
    #1 check("flush_wr_req", 128'(wr_req), 128'(1));
    grant = 1;
    step();
    grant = 0;
    store(36'h3, 16'h00FF, {16{8'h55}});
    #1;
    check("flush_empty",         128'(empty), 128'(1));
    check("flush_blocked_ready", 128'(rdy),   128'(0));
    step();
    flush = 0;
    step();                                  // allocates tag 3
    st_vld = 0;
    dis    = 1;
    step();                                  // disable forces drain
    dis     = 0;
    ld_addr = 40'h30;
    #1 check("dis_wr_req", 128'(wr_req), 128'(1));

    // Reset during DRAIN, then a stale grant.
    rst = 1;
    step();
    rst   = 0;
    grant = 1;
    #1;
    check("rst_wr_req", 128'(wr_req), 128'(0));
    check("rst_hit",    128'(hit),    128'(0));
    check("rst_empty",  128'(empty),  128'(1));
    step();
    grant = 0;
    #1 check("stale_grant_empty", 128'(empty), 128'(1));
    step();

    // Randomized traffic over a few segments.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      dis     = ($urandom_range(0, 39) == 0);
      icc     = ($urandom_range(0, 39) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      grant   = ($urandom_range(0, 2) == 0);
      st_vld  = ($urandom_range(0, 1) == 1);
      st_addr = 36'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       st_be = 16'h0000;
        1:       st_be = 16'($urandom);
        default: st_be = 16'($urandom & $urandom & $urandom);
      endcase
      st_data = {$urandom, $urandom, $urandom, $urandom};
      ld_addr = {36'($urandom_range(1, 3)), 4'($urandom)};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
